instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream over a valid/ready handshake and packs each group of 4 bytes into a 32-bit word.
- Writes each word into instruction memory at consecutive addresses starting at 0.
- Holds the CPU (PC register) in reset while loading, then releases it.
- Sits between a host byte source (UART receiver or testbench) and the write port of the instruction memory.

Parameters:
ADDR_W, 8, instruction memory address width (matches the 8-bit PC)
DATA_W, 32, instruction word width; fixed at 4 bytes per word

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a load; honoured only in IDLE
byte_in  input  8  incoming program byte
byte_valid  input  1  byte_in holds a valid byte
byte_ready  output  1  loader can accept a byte this cycle
we  output  1  instruction memory write enable, one cycle per word
wa  output  ADDR_W  instruction memory write address
wd  output  DATA_W  instruction memory write data
cpu_hold  output  1  high while loading; drives CPU/PC reset
busy  output  1  high in any state other than IDLE
done  output  1  single-cycle pulse when the load completes

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, byte_ready=0, we=0, wa=0, wd=0, cpu_hold=0, busy=0, done=0, internal byte counter=0, word counter=0, address=0.
- Handshake: a byte transfers on a rising edge where byte_valid && byte_ready. byte_ready is combinational from state only, never from byte_valid. The source holds byte_in stable while byte_valid && !byte_ready.
- FSM states: IDLE, LEN, DATA, WRITE, DONE.
- IDLE: byte_ready=0. start=1 -> LEN. At the same time, address and byte counter clear to 0 and cpu_hold rises on the next cycle.
- LEN: byte_ready=1. The accepted byte sets words_left (0x00 means 256 words). -> DATA.
- DATA: byte_ready=1. Bytes pack big-endian: 1st byte to wd[31:24], 2nd to [23:16], 3rd to [15:8], 4th to [7:0]. Accepting the 4th byte -> WRITE.
- WRITE: byte_ready=0. we=1 for exactly this cycle, with wa=current address and wd=the assembled word. Address increments, wrapping 255->0, and words_left decrements. If words_left was 1 -> DONE, else -> DATA.
- DONE: done=1 for one cycle, cpu_hold still 1. -> IDLE, where cpu_hold falls.
- Latency: the 4th byte accepted on edge N gives we=1 in cycle N+1. The last we cycle is followed by done for one cycle, then cpu_hold=0.
- cpu_hold = 1 in LEN, DATA, WRITE and DONE. busy = cpu_hold.
- start while busy: ignored, with no restart and no counter change.
- byte_valid while in IDLE or WRITE: not accepted; the byte stays pending at the source.
- wa and wd hold their last values outside WRITE. we=0 everywhere except WRITE.
- Gaps in byte_valid are allowed at any point and stall the FSM indefinitely.
- Reset mid-load: immediate return to IDLE with all outputs as at reset. Partially written memory contents are not rolled back.
- A 256-word load writes addresses 0..255. The address wraps to 0 after the final write, which is harmless.

Test Plan:
- Basic load: start; stream 0x02, 0x20,0x01,0x00,0x05, 0x01,0x22,0x18,0x20 -> we pulse 1: wa=0x00, wd=0x20010005; we pulse 2: wa=0x01, wd=0x01221820; done one cycle after pulse 2; cpu_hold high from the cycle after start through done.
- Stalled source: same stream with byte_valid low for 3 random cycles between every byte -> identical writes and data; no we while a word is incomplete; byte_ready never high in WRITE.
- Length 0x00: stream 1024 bytes with byte k = k mod 256 -> 256 writes at wa=0x00..0xFF; word at 0x03 is 0x0C0D0E0F; exactly one done.
- Start while busy: pulse start during DATA after byte 2 of word 0 -> no restart; load completes as in the basic load.
- Async reset mid-load: drop rst_n after 6 data bytes, with no clock edge needed -> outputs zero immediately; after release, a new start with a 1-word load writes wa=0x00.
- Back-to-back loads: after done, start a 1-word load of 0xDEADBEEF -> write at wa=0x00, showing the address restarted and not continuing from the previous load.

Source files
------------

// File: rtl/instr_loader.sv
// Instruction memory loader: accepts a length-prefixed program as a byte
// stream, packs bytes big-endian into 32-bit words, writes them to
// consecutive addresses from 0, and holds the CPU in reset while loading.
module instr_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [7:0]        words_left;   // 0 encodes 256: decrementing wraps through 255..1
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] addr;         // address of the next word to be written
    logic [DATA_W-1:0] shift_q;      // word under assembly, shifts left per byte
    logic [ADDR_W-1:0] wa_q;
    logic [DATA_W-1:0] wd_q;
    logic              xfer;

    // byte_ready depends only on state, so the source never sees a combinational loop
    assign byte_ready = (state == S_LEN) || (state == S_DATA);
    assign xfer       = byte_valid && byte_ready;
    assign we         = (state == S_WRITE);
    assign done       = (state == S_DONE);
    assign cpu_hold   = (state != S_IDLE);
    assign busy       = cpu_hold;
    assign wa         = wa_q;
    assign wd         = wd_q;

    // Control FSM with address, length and byte counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            words_left <= 8'd0;
            byte_cnt   <= 2'd0;
            addr       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LEN;
                        addr     <= '0;
                        byte_cnt <= 2'd0;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        words_left <= byte_in;
                        state      <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    addr       <= addr + ADDR_ONE;
                    words_left <= words_left - 8'd1;
                    state      <= (words_left == 8'd1) ? S_DONE : S_DATA;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte packing and write-port registers; wa/wd only change when a word completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else if (state == S_DATA && xfer) begin
            shift_q <= {shift_q[DATA_W-9:0], byte_in};
            if (byte_cnt == 2'd3) begin
                wd_q <= {shift_q[DATA_W-9:0], byte_in};
                wa_q <= addr;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader: drives byte streams at negedge+1,
// records memory writes and done pulses from a negedge monitor.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        cpu_hold;
    logic        busy;
    logic        done;

    int vectors = 0;
    int errors  = 0;

    int cyc = 0;
    int wcnt = 0;
    int done_cnt = 0;
    int done_gap = 0;
    int last_we_cyc = 0;
    int ready_in_write = 0;
    logic [7:0]  cap_wa [0:511];
    logic [31:0] cap_wd [0:511];

    instr_loader #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Monitor: capture every write and every done pulse
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (we === 1'b1) begin
            if (wcnt < 512) begin
                cap_wa[wcnt] = wa;
                cap_wd[wcnt] = wd;
            end
            wcnt = wcnt + 1;
            last_we_cyc = cyc;
            if (byte_ready !== 1'b0) ready_in_write = ready_in_write + 1;
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_gap = cyc - last_we_cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 0;
        byte_in = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (byte_ready === 1'b1) ok = 1;
            tick();
        end
        byte_valid = 1'b0;
        if (!ok) begin
            vectors++;
            errors++;
            $display("FAIL send_byte timeout: byte_ready stayed low, got %b want 1", byte_ready);
        end
    endtask

    // Sends a whole stream; optional idle gaps and an optional start pulse after byte index busy_idx
    task automatic send_stream(input logic [7:0] q[$], input int gap, input int busy_idx);
        for (int k = 0; k < q.size(); k++) begin
            send_byte(q[k]);
            if (k == busy_idx) pulse_start();
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic wait_done(input int base);
        for (int i = 0; i < 100 && done_cnt == base; i++) tick();
        vectors++;
        if (done_cnt == base) begin
            errors++;
            $display("FAIL done_timeout: done_cnt=%0d want >%0d", done_cnt, base);
        end
    endtask

    // Common checks for the 2-word program 02 20010005 01221820
    task automatic check_basic(input string tag, input int bw, input int bd);
        vectors++;
        if (done !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL %s done_hold: done=%b cpu_hold=%b want 1 1", tag, done, cpu_hold);
        end
        vectors++;
        if (wcnt - bw != 2) begin
            errors++;
            $display("FAIL %s write_count: got %0d want 2", tag, wcnt - bw);
        end
        vectors++;
        if (cap_wa[bw] !== 8'h00 || cap_wd[bw] !== 32'h20010005) begin
            errors++;
            $display("FAIL %s write0: wa=%h wd=%h want 00 20010005", tag, cap_wa[bw], cap_wd[bw]);
        end
        vectors++;
        if (cap_wa[bw+1] !== 8'h01 || cap_wd[bw+1] !== 32'h01221820) begin
            errors++;
            $display("FAIL %s write1: wa=%h wd=%h want 01 01221820", tag, cap_wa[bw+1], cap_wd[bw+1]);
        end
        vectors++;
        if (done_gap != 1 || done_cnt - bd != 1) begin
            errors++;
            $display("FAIL %s done_timing: gap=%0d count=%0d want 1 1", tag, done_gap, done_cnt - bd);
        end
        tick();
        vectors++;
        if (cpu_hold !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s release: cpu_hold=%b busy=%b done=%b want 0 0 0", tag, cpu_hold, busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        tick();
        tick();
        vectors++;
        if ({byte_ready, we, wa, wd, cpu_hold, busy, done} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b we=%b wa=%h wd=%h hold=%b busy=%b done=%b want all 0",
                     byte_ready, we, wa, wd, cpu_hold, busy, done);
        end
        rst_n = 1'b1;
        byte_valid = 1'b1;
        tick();
        tick();
        vectors++;
        if (byte_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_accept: byte_ready=%b busy=%b want 0 0", byte_ready, busy);
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_basic_load();
        int bw, bd;
        logic [7:0] q[$];
        bw = wcnt;
        bd = done_cnt;
        q = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h01, 8'h22, 8'h18, 8'h20};
        pulse_start();
        vectors++;
        if (cpu_hold !== 1'b1 || busy !== 1'b1 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic hold_after_start: hold=%b busy=%b ready=%b want 1 1 1", cpu_hold, busy, byte_ready);
        end
        send_stream(q, 0, -1);
        wait_done(bd);
        check_basic("basic", bw, bd);
    endtask

    task automatic test_back_to_back();
        int bw, bd;
        logic [7:0] q[$];
        bw = wcnt;
        bd = done_cnt;
        q = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        pulse_start();
        send_stream(q, 0, -1);
        wait_done(bd);
        vectors++;
        if (wcnt - bw != 1 || cap_wa[bw] !== 8'h00 || cap_wd[bw] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL b2b write: n=%0d wa=%h wd=%h want 1 00 deadbeef", wcnt - bw, cap_wa[bw], cap_wd[bw]);
        end
        tick();
    endtask

    task automatic test_stalled();
        int bw, bd, rw;
        logic [7:0] q[$];
        bw = wcnt;
        bd = done_cnt;
        rw = ready_in_write;
        q = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h01, 8'h22, 8'h18, 8'h20};
        pulse_start();
        send_byte(q[0]);
        for (int k = 1; k < q.size(); k++) begin
            for (int g = 0; g < 3; g++) tick();
            if (k == 4) begin
                vectors++;
                if (wcnt != bw) begin
                    errors++;
                    $display("FAIL stall partial_word: writes=%0d want 0", wcnt - bw);
                end
            end
            send_byte(q[k]);
        end
        wait_done(bd);
        check_basic("stall", bw, bd);
        vectors++;
        if (ready_in_write != rw) begin
            errors++;
            $display("FAIL stall ready_in_write: got %0d want 0", ready_in_write - rw);
        end
    endtask

    task automatic test_start_busy();
        int bw, bd;
        logic [7:0] q[$];
        bw = wcnt;
        bd = done_cnt;
        q = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h01, 8'h22, 8'h18, 8'h20};
        pulse_start();
        send_stream(q, 0, 2);
        wait_done(bd);
        check_basic("start_busy", bw, bd);
    endtask

    task automatic test_len_zero();
        int bw, bd;
        int bad_wa, bad_wd;
        logic [31:0] exp;
        logic [7:0] q[$];
        bw = wcnt;
        bd = done_cnt;
        q.push_back(8'h00);
        for (int k = 0; k < 1024; k++) q.push_back(8'(k));
        pulse_start();
        send_stream(q, 0, -1);
        wait_done(bd);
        vectors++;
        if (wcnt - bw != 256) begin
            errors++;
            $display("FAIL len0 write_count: got %0d want 256", wcnt - bw);
        end
        bad_wa = 0;
        bad_wd = 0;
        for (int j = 0; j < 256; j++) begin
            exp = {8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3)};
            if (cap_wa[bw+j] !== 8'(j)) bad_wa++;
            if (cap_wd[bw+j] !== exp) bad_wd++;
        end
        vectors++;
        if (bad_wa != 0 || bad_wd != 0) begin
            errors++;
            $display("FAIL len0 sequence: bad_wa=%0d bad_wd=%0d want 0 0", bad_wa, bad_wd);
        end
        vectors++;
        if (cap_wa[bw+3] !== 8'h03 || cap_wd[bw+3] !== 32'h0C0D0E0F) begin
            errors++;
            $display("FAIL len0 word3: wa=%h wd=%h want 03 0c0d0e0f", cap_wa[bw+3], cap_wd[bw+3]);
        end
        vectors++;
        if (cap_wa[bw+255] !== 8'hFF) begin
            errors++;
            $display("FAIL len0 last_addr: wa=%h want ff", cap_wa[bw+255]);
        end
        tick();
        tick();
        vectors++;
        if (done_cnt - bd != 1) begin
            errors++;
            $display("FAIL len0 done_count: got %0d want 1", done_cnt - bd);
        end
    endtask

    task automatic test_async_reset();
        int bw, bd;
        logic [7:0] q[$];
        q = '{8'h02, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1};
        pulse_start();
        send_stream(q, 0, -1);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({byte_ready, we, wa, wd, cpu_hold, busy, done} !== 45'd0) begin
            errors++;
            $display("FAIL async_reset outputs: ready=%b we=%b wa=%h wd=%h hold=%b busy=%b done=%b want all 0",
                     byte_ready, we, wa, wd, cpu_hold, busy, done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        bw = wcnt;
        bd = done_cnt;
        q = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        pulse_start();
        send_stream(q, 0, -1);
        wait_done(bd);
        vectors++;
        if (wcnt - bw != 1 || cap_wa[bw] !== 8'h00 || cap_wd[bw] !== 32'h11223344) begin
            errors++;
            $display("FAIL async_reset reload: n=%0d wa=%h wd=%h want 1 00 11223344", wcnt - bw, cap_wa[bw], cap_wd[bw]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_back_to_back();
        test_stalled();
        test_start_busy();
        test_len_zero();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
